clock_monitor: RTL and testbench
================================

// Module: clock_monitor
// PURPOSE
//  Fast-domain receiver for a slow or divided clock, e.g. the output of the clock divider or an external slow clock.
//  Synchronises the sensed clock into clock_in and emits one-cycle rise/fall pulses.
//  Measures the period in clock_in cycles and flags loss of the sensed clock after a timeout.
//  Sits beside the clock divider; processor and peripherals use its pulses as clock enables.
// PARAMETERS
//  CNT_WIDTH   28          width of cycle counter, period and high_time
//  TIMEOUT     28'd120000  clock_in cycles without a rising edge before clock_lost; 2 <= TIMEOUT < 2**CNT_WIDTH
//  SYNC_STAGES 2           synchroniser flops, >= 2
// PORTS
//  clock_in     in   1          system clock; all logic on posedge
//  reset_n      in   1          asynchronous, active-low reset
//  sense_in     in   1          monitored clock; asynchronous to clock_in
//  rise_pulse   out  1          one-cycle pulse per synchronised rising edge
//  fall_pulse   out  1          one-cycle pulse per synchronised falling edge
//  period       out  CNT_WIDTH  last measured rise-to-rise distance in clock_in cycles
//  period_valid out  1          one-cycle strobe when period updates
//  clock_lost   out  1          level; sensed clock absent for TIMEOUT cycles
//  high_time    out  CNT_WIDTH  rise-to-fall distance; present only with CLOCK_MONITOR_DUTY_EN
// BEHAVIOUR
//  - Reset (async on reset_n low, released synchronously): all outputs 0.
//    Reset also clears the synchroniser, the last-level flop, the counter and the FSM (IDLE).
//  - Edge detect: sync = last synchroniser stage; prev = registered sync.
//    rise = sync & ~prev; fall = ~sync & prev.
//  - Pulse latency: the pulse is registered. It is high during the cycle after SYNC_STAGES+1 clock_in edges.
//    Counting starts from the first edge that samples the new sense_in level.
//  - Counter: cleared to 0 on a rise event, otherwise incremented. It saturates at TIMEOUT-1.
//  - On a rise event in ARMED: period <= cnt+1; period_valid pulses in the same cycle as rise_pulse.
//    Example: sense_in period D gives period = D.
//  - FSM states and transitions:
//    IDLE -rise-> ARMED: no period_valid.
//    ARMED -rise-> ARMED: period_valid.
//    IDLE or ARMED -(cnt==TIMEOUT-1, no rise)-> LOST: clock_lost <= 1.
//    LOST -rise-> ARMED: clock_lost <= 0, no period_valid.
//  - A rise event and a timeout in the same cycle: the rise wins and the FSM does not enter LOST.
//  - In LOST: period holds its last value and the counter stays saturated.
//  - A fall event never changes FSM state.
//  - Reset mid-measurement discards the partial count. No period_valid is generated after reset until two rises.
// CONFIGURATION
//  CLOCK_MONITOR_DUTY_EN defined:
//   - The high_time port exists.
//   - On a fall event in ARMED with no timeout since the last rise: high_time <= cnt+1. It resets to 0.
//  CLOCK_MONITOR_DUTY_EN undefined:
//   - The high_time port and its register are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  - clock_monitor_defs.vh holds the FSM state localparams (IDLE=2'd0, ARMED=2'd1, LOST=2'd2).
//    It also holds the default TIMEOUT and CNT_WIDTH, shared with the clock divider.
//  - Sub-module sync_edge_detect, parameter SYNC_STAGES:
//    inputs clock_in, reset_n, async_in; outputs level, rise, fall.
//    It is reusable for the processor's button inputs.
//  - The top level holds the counter, FSM, period/high_time registers and the registered pulses.
// TESTING
//  1. sense_in from clock_divider (DIVISOR 60000), 3 periods:
//     - the first rise gives no period_valid;
//     - then period=60000 per rise, clock_lost=0.
//  2. Measure the delay from sense_in 0->1 to rise_pulse.
//     Required: exactly SYNC_STAGES+1 edges (3 with defaults); pulse width 1 cycle; fall_pulse likewise.
//  3. Stop sense_in low after a rise, TIMEOUT=100.
//     - clock_lost=1 100 cycles after that rise; period holds its value.
//     - The next rise clears clock_lost with no period_valid.
//     - The rise after that gives a correct period.
//  4. Force a rise on the exact cycle cnt reaches TIMEOUT-1.
//     Required: period_valid, period=TIMEOUT, clock_lost stays 0.
//  5. Assert reset_n low mid-period, then release.
//     - All outputs 0 immediately.
//     - The first post-reset rise gives no period_valid; the second gives the correct period.
//  6. With CLOCK_MONITOR_DUTY_EN, sense_in high 20 / low 60 cycles: high_time=20, period=80.
//     Without the macro the port must be absent and tests 1-5 still pass.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding and the default counter
// width and loss timeout, which the clock divider also uses.
package clock_monitor_pkg;

  localparam int unsigned DefCntWidth = 28;
  localparam int unsigned DefTimeout  = 120000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StLost  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level with registered-previous edge detect.
// Reusable for any slow asynchronous input (sensed clocks, push buttons).
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/clock_monitor.sv
// Clock monitor: synchronises a slow sensed clock, emits edge pulses, measures its period and
// flags its loss. Define CLOCK_MONITOR_DUTY_EN to add the high_time (rise-to-fall) measurement.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DefCntWidth,
  parameter int unsigned TIMEOUT     = DefTimeout,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 sense_in,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
`ifdef CLOCK_MONITOR_DUTY_EN
  output logic [CNT_WIDTH-1:0] high_time,
`endif
  output logic                 clock_lost
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT - 1);

  logic unused_level;
  logic level, rise_ev, fall_ev;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .async_in(sense_in),
    .level   (level),
    .rise    (rise_ev),
    .fall    (fall_ev)
  );

  assign unused_level = level;

  // Cycles since the last rise event; saturates so a lost clock is never re-measured.
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_max;

  assign at_max = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(1);
    if (rise_ev) begin
      cnt_d = '0;
    end else if (at_max) begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  state_e state_q, state_d;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A rise coinciding with the timeout wins; falls never move the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rise_ev) begin
          state_d = StArmed;
        end else if (at_max) begin
          state_d = StLost;
        end
      end
      StArmed: begin
        if (!rise_ev && at_max) begin
          state_d = StLost;
        end
      end
      StLost: begin
        if (rise_ev) begin
          state_d = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clock_lost = (state_q == StLost);
  end

  logic                 rise_q, fall_q, period_valid_q, period_valid_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;

  always_comb begin
    period_valid_d = rise_ev && (state_q == StArmed);
    period_d       = period_q;
    if (period_valid_d) begin
      period_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      period_valid_q <= 1'b0;
      period_q       <= '0;
    end else begin
      rise_q         <= rise_ev;
      fall_q         <= fall_ev;
      period_valid_q <= period_valid_d;
      period_q       <= period_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period_valid = period_valid_q;
  assign period       = period_q;

`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;

  // A fall on the saturating cycle belongs to a high phase that already timed out.
  always_comb begin
    high_time_d = high_time_q;
    if (fall_ev && (state_q == StArmed) && !at_max) begin
      high_time_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      high_time_q <= '0;
    end else begin
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  // Without duty measurement, fall events only drive fall_pulse.
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Randomised bench for clock_monitor against an event-level model of edges, periods and loss,
// plus a default-parameter instance fed by a divided clock.
module tb_clock_monitor;

  localparam int W  = 28;
  localparam int TO = 100;
  localparam int S  = 2;
  localparam int DIV_HALF = 3000;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  logic sense_in = 1'b0;
  logic rise_pulse, fall_pulse, period_valid, clock_lost;
  logic [W-1:0] period;
`ifdef CLOCK_MONITOR_DUTY_EN
  logic [W-1:0] high_time;
  logic [W-1:0] div_high_time;
`endif

  logic div_reset_n = 1'b0;
  logic sense_div   = 1'b0;
  logic div_rise, div_fall, div_pv, div_lost;
  logic [W-1:0] div_period;
  bit   div_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock_in = ~clock_in;

  clock_monitor #(
    .CNT_WIDTH  (W),
    .TIMEOUT    (TO),
    .SYNC_STAGES(S)
  ) u_dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .sense_in    (sense_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period      (period),
    .period_valid(period_valid),
`ifdef CLOCK_MONITOR_DUTY_EN
    .high_time   (high_time),
`endif
    .clock_lost  (clock_lost)
  );

  clock_monitor u_div (
    .clock_in    (clock_in),
    .reset_n     (div_reset_n),
    .sense_in    (sense_div),
    .rise_pulse  (div_rise),
    .fall_pulse  (div_fall),
    .period      (div_period),
    .period_valid(div_pv),
`ifdef CLOCK_MONITOR_DUTY_EN
    .high_time   (div_high_time),
`endif
    .clock_lost  (div_lost)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sampled sense_in history; a change seen at edge j shows as a pulse at edge j+S.
  // Periods are distances between pulse edges; loss is TO edges without a rise.
  logic [S+1:0] hist = '0;
  int     k = 0, last_ref = 0;
  bit     have_rise = 1'b0;
  bit     m_rise = 1'b0, m_fall = 1'b0, m_pv = 1'b0, m_lost = 1'b0;
  longint m_period = 0, m_high = 0;

  always @(posedge clock_in) begin
    if (!reset_n) begin
      hist = '0; k = 0; last_ref = 0; have_rise = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_pv = 1'b0; m_lost = 1'b0;
      m_period = 0; m_high = 0;
    end else begin
      k++;
      hist   = {hist[S:0], sense_in};
      m_rise = hist[S] & ~hist[S+1];
      m_fall = ~hist[S] & hist[S+1];
      m_pv   = 1'b0;
      if (m_fall && have_rise && (k - last_ref) < TO) m_high = k - last_ref;
      if (m_rise) begin
        if (have_rise && (k - last_ref) <= TO) begin
          m_pv     = 1'b1;
          m_period = k - last_ref;
        end
        have_rise = 1'b1;
        last_ref  = k;
        m_lost    = 1'b0;
      end else if ((k - last_ref) >= TO) begin
        m_lost = 1'b1;
      end
    end
  end

  int     pv_cnt = 0;
  longint pv_last = 0;

  always @(negedge clock_in) begin
    check("rise_pulse", rise_pulse, m_rise);
    check("fall_pulse", fall_pulse, m_fall);
    check("period_valid", period_valid, m_pv);
    check("period", period, m_period);
    check("clock_lost", clock_lost, m_lost);
`ifdef CLOCK_MONITOR_DUTY_EN
    check("high_time", high_time, m_high);
`endif
    if (period_valid === 1'b1) begin
      pv_cnt++;
      pv_last = period;
    end
  end

  int div_rise_cnt = 0, div_pv_cnt = 0;

  always @(negedge clock_in) begin
    if (div_rise === 1'b1) begin
      if (div_rise_cnt == 0) check("div_first_rise_no_pv", div_pv, 0);
      div_rise_cnt++;
    end
    if (div_pv === 1'b1) begin
      div_pv_cnt++;
      check("div_period", div_period, 2 * DIV_HALF);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock_in);
      #2;
    end
  endtask

  task automatic wave(input int hi, input int lo);
    sense_in = 1'b1;
    tick(hi);
    sense_in = 1'b0;
    tick(lo);
  endtask

  task automatic measure(input string name, input logic lvl);
    int first, width;
    first = 0;
    width = 0;
    sense_in = lvl;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock_in);
      #1;
      if ((lvl ? rise_pulse : fall_pulse) === 1'b1) begin
        if (first == 0) first = i;
        width++;
      end
    end
    check({name, "_latency"}, first, S + 1);
    check({name, "_width"}, width, 1);
    tick(1);
  endtask

  // Divided-clock source, scaled down so the run stays short.
  initial begin
    tick(3);
    div_reset_n = 1'b1;
    for (int h = 0; h < 7; h++) begin
      sense_div = ~sense_div;
      tick(DIV_HALF);
    end
    check("div_pv_count", div_pv_cnt, 3);
    check("div_rise_count", div_rise_cnt, 4);
    check("div_clock_lost", div_lost, 0);
    div_done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  int p0, hi, lo;

  initial begin
    tick(3);
    check("rst_rise", rise_pulse, 0);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_lost", clock_lost, 0);
    reset_n = 1'b1;
    tick(5);

    measure("rise", 1'b1);
    tick(20);
    measure("fall", 1'b0);
    tick(20);
    check("first_rise_no_pv", pv_cnt, 0);

    wave(20, 20);
    wave(20, 20);
    wave(20, 20);
    wave(20, 120);
    check("period_40", pv_last, 40);
    check("lost_after_gap", clock_lost, 1);
    check("period_held", period, 40);

    p0 = pv_cnt;
    wave(30, 30);
    check("recover_no_pv", pv_cnt, p0);
    check("recover_lost_clear", clock_lost, 0);
    wave(30, 30);
    check("recover_pv_count", pv_cnt, p0 + 1);
    check("recover_period", pv_last, 60);

    wave(50, 50);
    wave(50, 50);
    wave(50, 50);
    check("exact_timeout_period", pv_last, TO);
    check("exact_timeout_not_lost", clock_lost, 0);

    wave(20, 60);
    wave(20, 60);
    check("duty_period", pv_last, 80);
`ifdef CLOCK_MONITOR_DUTY_EN
    check("duty_high_time", high_time, 20);
`endif

    sense_in = 1'b1;
    tick(10);
    reset_n = 1'b0;
    #1;
    check("midrst_rise", rise_pulse, 0);
    check("midrst_fall", fall_pulse, 0);
    check("midrst_pv", period_valid, 0);
    check("midrst_period", period, 0);
    check("midrst_lost", clock_lost, 0);
    tick(3);
    p0 = pv_cnt;
    reset_n = 1'b1;
    tick(30);
    sense_in = 1'b0;
    tick(20);
    check("postrst_first_no_pv", pv_cnt, p0);
    wave(25, 25);
    check("postrst_pv_count", pv_cnt, p0 + 1);
    check("postrst_period", pv_last, 50);

    for (int i = 0; i < 150; i++) begin
      hi = $urandom_range(1, 60);
      lo = $urandom_range(1, 60);
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(90, 130);
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        tick($urandom_range(1, 3));
        reset_n = 1'b1;
      end
      wave(hi, lo);
    end
    tick(10);

    wait (div_done);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
